// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: one shadow entry per in-flight stage,
// plus the "writes register r" predicate used by every comparator.
package hazard_pkg;

  localparam int MAX_ADDR_W  = 8;
  localparam int FWD_REGFILE = 0;

  typedef logic [MAX_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
    logic     isload;
  } stage_entry_t;

  // x0 is hardwired, so a stage targeting it never produces a value anyone waits on.
  function automatic logic entry_writes(input stage_entry_t e, input reg_idx_t r);
    return e.valid && e.regwrite && (e.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipe_dest_track.sv
// Shift register of destination entries for the stages after EX (M1..Mn, WB).
// Index 0 is M1, index DEPTH-1 is WB.
import hazard_pkg::*;

module pipe_dest_track #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  stage_entry_t             in_entry,
  input  logic                     bubble,
  output stage_entry_t [DEPTH-1:0] stages
);

  stage_entry_t [DEPTH-1:0] stages_d;
  stage_entry_t [DEPTH-1:0] stages_q;
  stage_entry_t             head;

  always_comb begin
    head       = in_entry;
    head.valid = in_entry.valid && !bubble;
    stages_d   = {stages_q[DEPTH-2:0], head};
  end

  // Only the valid bits need clearing; stale payload behind a cleared valid is inert.
  always_ff @(posedge clk) begin
    stages_q <= stages_d;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages_q[i].valid <= 1'b0;
      end
    end
  end

  assign stages = stages_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall, flush and forwarding control for the IF/ID/EX/M1..Mn/WB pipeline,
// driven by a private shadow of each in-flight instruction's destination.
import hazard_pkg::*;

module pipeline_hazard_unit #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEM_STAGES    = 1,
  parameter int FWD_WIDTH     = $clog2(MEM_STAGES + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [ADDRESS_WIDTH-1:0] id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_isload,
  input  logic                     ex_redirect,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     flush_id,
  output logic                     bubble_ex,
  output logic [FWD_WIDTH-1:0]     fwd_a,
  output logic [FWD_WIDTH-1:0]     fwd_b,
  output logic                     id_wb_byp_rs1,
  output logic                     id_wb_byp_rs2
);

  localparam int DEPTH = MEM_STAGES + 1;

  if (MEM_STAGES < 1 || MEM_STAGES > 3) begin : g_bad_mem_stages
    $error("pipeline_hazard_unit: MEM_STAGES must be 1..3");
  end
  if (FWD_WIDTH != $clog2(MEM_STAGES + 2)) begin : g_bad_fwd_width
    $error("pipeline_hazard_unit: FWD_WIDTH is derived and must not be overridden");
  end
  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > MAX_ADDR_W) begin : g_bad_addr_width
    $error("pipeline_hazard_unit: ADDRESS_WIDTH out of range");
  end

  function automatic reg_idx_t widen(input logic [ADDRESS_WIDTH-1:0] a);
    return reg_idx_t'(a);
  endfunction

  stage_entry_t             ex_d, ex_q;
  reg_idx_t                 ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q;
  logic                     ex_use_rs1_d, ex_use_rs1_q, ex_use_rs2_d, ex_use_rs2_q;
  stage_entry_t [DEPTH-1:0] mem_wb;

  reg_idx_t             id_rs1_w, id_rs2_w;
  logic                 ld_rs1, ld_rs2, load_hz;
  logic [FWD_WIDTH-1:0] fwd_a_c, fwd_b_c;

  assign id_rs1_w = widen(id_rs1);
  assign id_rs2_w = widen(id_rs2);

  // ---- ID -> EX boundary ----
  always_comb begin
    ex_d.valid    = id_valid && !bubble_ex;
    ex_d.rd       = widen(id_rd);
    ex_d.regwrite = id_regwrite;
    ex_d.isload   = id_isload;
    ex_rs1_d      = id_rs1_w;
    ex_rs2_d      = id_rs2_w;
    ex_use_rs1_d  = id_use_rs1;
    ex_use_rs2_d  = id_use_rs2;
  end

  always_ff @(posedge clk) begin
    ex_q         <= ex_d;
    ex_rs1_q     <= ex_rs1_d;
    ex_rs2_q     <= ex_rs2_d;
    ex_use_rs1_q <= ex_use_rs1_d;
    ex_use_rs2_q <= ex_use_rs2_d;
    if (rst) begin
      ex_q.valid <= 1'b0;
    end
  end

  // ---- EX -> M1..Mn -> WB boundaries ----
  pipe_dest_track #(
    .DEPTH(DEPTH)
  ) u_track (
    .clk     (clk),
    .rst     (rst),
    .in_entry(ex_q),
    .bubble  (1'b0),
    .stages  (mem_wb)
  );

  // A load's data only appears in WB, so a load in EX or any Mk except the last blocks ID.
  always_comb begin
    ld_rs1 = entry_writes(ex_q, id_rs1_w) && ex_q.isload;
    ld_rs2 = entry_writes(ex_q, id_rs2_w) && ex_q.isload;
    for (int k = 0; k < MEM_STAGES - 1; k++) begin
      ld_rs1 = ld_rs1 || (entry_writes(mem_wb[k], id_rs1_w) && mem_wb[k].isload);
      ld_rs2 = ld_rs2 || (entry_writes(mem_wb[k], id_rs2_w) && mem_wb[k].isload);
    end
    load_hz = id_valid && ((id_use_rs1 && ld_rs1) || (id_use_rs2 && ld_rs2));
  end

  // Scan oldest to youngest so the youngest matching producer is the last assignment.
  always_comb begin
    fwd_a_c = FWD_WIDTH'(FWD_REGFILE);
    fwd_b_c = FWD_WIDTH'(FWD_REGFILE);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ex_q.valid && ex_use_rs1_q && entry_writes(mem_wb[i], ex_rs1_q) &&
          (i == DEPTH - 1 || !mem_wb[i].isload)) begin
        fwd_a_c = FWD_WIDTH'(i + 1);
      end
      if (ex_q.valid && ex_use_rs2_q && entry_writes(mem_wb[i], ex_rs2_q) &&
          (i == DEPTH - 1 || !mem_wb[i].isload)) begin
        fwd_b_c = FWD_WIDTH'(i + 1);
      end
    end
  end

  // A redirect squashes the instruction in ID, so any stall it would need is moot.
  assign stall_if      = load_hz && !ex_redirect;
  assign stall_id      = load_hz && !ex_redirect;
  assign flush_id      = ex_redirect;
  assign bubble_ex     = ex_redirect || load_hz;
  assign fwd_a         = fwd_a_c;
  assign fwd_b         = fwd_b_c;
  assign id_wb_byp_rs1 = id_use_rs1 && entry_writes(mem_wb[DEPTH-1], id_rs1_w);
  assign id_wb_byp_rs2 = id_use_rs2 && entry_writes(mem_wb[DEPTH-1], id_rs2_w);

endmodule
